switch_arbiter: RTL and testbench

Round-robin switch arbiter for the router datapath. It sits between the per-input-channel receivers (`rx`) and a single shared output transmitter (`tx`). It picks one requesting input and forwards that input's request to the transmitter. It routes the transmitter's grant back to the chosen input, and drives `selected` so the surrounding logic can mux that input's channel number and buffer data.

---
 rtl/switch_pkg.sv | 12 +
 rtl/rr_picker.sv | 37 +++
 rtl/switch_arbiter.sv | 67 ++++++
 tb/tb_switch_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// Shared types and defaults for the round-robin switch arbiter.
package switch_pkg;

  localparam int CHANNELS_DEFAULT = 5;
  localparam int SEL_BITS_DEFAULT = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: rotate requests so ptr sits at bit 0,
// take the lowest set bit, then map the offset back to a channel index.
module rr_picker
  import switch_pkg::*;
#(
  parameter int CHANNELS = CHANNELS_DEFAULT,
  parameter int SEL_BITS = SEL_BITS_DEFAULT
) (
  input  logic [CHANNELS-1:0] reqs,
  input  logic [SEL_BITS-1:0] ptr,
  output logic [SEL_BITS-1:0] winner,
  output logic                any
);

  localparam logic [SEL_BITS:0] CH_W = (SEL_BITS+1)'(CHANNELS);

  logic [2*CHANNELS-1:0] dbl;
  logic [CHANNELS-1:0]   rot;
  logic [SEL_BITS-1:0]   offset;
  logic [SEL_BITS:0]     sum;

  assign dbl = {reqs, reqs} >> ptr;
  assign rot = dbl[CHANNELS-1:0];
  assign any = |rot;

  // Descending loop so the lowest set bit is the last (winning) assignment.
  always_comb begin
    offset = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (rot[i]) offset = SEL_BITS'(i);
    end
  end

  assign sum    = {1'b0, ptr} + {1'b0, offset};
  assign winner = (sum >= CH_W) ? SEL_BITS'(sum - CH_W) : sum[SEL_BITS-1:0];

endmodule

// File: rtl/switch_arbiter.sv
// Round-robin arbiter granting one receiver at a time to the shared
// transmitter; request and grant are passed through combinationally while BUSY.
module switch_arbiter
  import switch_pkg::*;
#(
  parameter int CHANNELS = CHANNELS_DEFAULT,
  parameter int SEL_BITS = SEL_BITS_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] reqs_in,
  output logic [CHANNELS-1:0] acks_in,
  output logic                req_out,
  input  logic                ack_out,
  output logic [SEL_BITS-1:0] selected
);

  localparam logic [SEL_BITS-1:0] LAST = SEL_BITS'(CHANNELS - 1);

  arb_state_t          state;
  logic [SEL_BITS-1:0] ptr;
  logic [SEL_BITS-1:0] winner;
  logic                any;

  rr_picker #(
    .CHANNELS(CHANNELS),
    .SEL_BITS(SEL_BITS)
  ) u_picker (
    .reqs  (reqs_in),
    .ptr   (ptr),
    .winner(winner),
    .any   (any)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ptr      <= '0;
      selected <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            selected <= winner;
            ptr      <= (winner == LAST) ? '0 : winner + 1'b1;
            state    <= BUSY;
          end
        end
        BUSY: begin
          // Release only once both sides of the 4-phase handshake are low.
          if (!reqs_in[selected] && !ack_out) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    req_out = 1'b0;
    acks_in = '0;
    if (state == BUSY) begin
      req_out           = reqs_in[selected];
      acks_in[selected] = ack_out;
    end
  end

endmodule

// File: tb/tb_switch_arbiter.sv
// Self-checking bench for switch_arbiter: directed scenarios plus randomized
// traffic compared against a behavioural round-robin model.
module tb_switch_arbiter;
  localparam int CH = 5;
  localparam int SB = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [CH-1:0] reqs_in = '0;
  logic [CH-1:0] acks_in;
  logic          req_out;
  logic          ack_out = 1'b0;
  logic [SB-1:0] selected;

  int checks = 0;
  int errors = 0;

  switch_arbiter #(.CHANNELS(CH), .SEL_BITS(SB)) dut (
    .clk     (clk),
    .reset   (reset),
    .reqs_in (reqs_in),
    .acks_in (acks_in),
    .req_out (req_out),
    .ack_out (ack_out),
    .selected(selected)
  );

  always #5 clk = ~clk;

  // Behavioural model: owner index, priority index, busy flag.
  bit m_busy;
  int m_ptr;
  int m_sel;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy <= 1'b0;
      m_ptr  <= 0;
      m_sel  <= 0;
    end else if (!m_busy) begin
      if (reqs_in != '0) begin
        int found;
        found = -1;
        for (int k = 0; k < CH; k++) begin
          if (found < 0 && reqs_in[(m_ptr + k) % CH]) found = (m_ptr + k) % CH;
        end
        m_sel  <= found;
        m_ptr  <= (found + 1) % CH;
        m_busy <= 1'b1;
      end
    end else if (!reqs_in[m_sel] && !ack_out) begin
      m_busy <= 1'b0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reqs_in = '0;
    ack_out = 1'b0;
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (req_out !== 1'b0 || acks_in !== '0 || selected !== '0) begin
      errors++;
      $display("FAIL reset_vals: req_out=%b acks_in=%b selected=%0d expected 0/00000/0",
               req_out, acks_in, selected);
    end
  endtask

  task automatic test_single();
    do_reset();
    reqs_in = 5'b00100;
    #1;
    checks++;
    if (req_out !== 1'b0) begin
      errors++; $display("FAIL single_idle_req: req_out=%b expected 0", req_out);
    end
    cyc();
    checks++;
    if (selected !== 3'd2 || req_out !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: selected=%0d req_out=%b expected 2/1", selected, req_out);
    end
    ack_out = 1'b1;
    #1;
    checks++;
    if (acks_in !== 5'b00100) begin
      errors++; $display("FAIL single_ack: acks_in=%b expected 00100", acks_in);
    end
    cyc();
    reqs_in = '0;
    #1;
    checks++;
    if (req_out !== 1'b0 || acks_in !== 5'b00100) begin
      errors++;
      $display("FAIL single_req_drop: req_out=%b acks_in=%b expected 0/00100", req_out, acks_in);
    end
    cyc();
    ack_out = 1'b0;
    #1;
    checks++;
    if (acks_in !== '0) begin
      errors++; $display("FAIL single_ack_drop: acks_in=%b expected 00000", acks_in);
    end
    cyc();
    reqs_in = 5'b00001;
    #1;
    checks++;
    if (req_out !== 1'b0 || selected !== 3'd2) begin
      errors++;
      $display("FAIL single_idle_after: req_out=%b selected=%0d expected 0/2", req_out, selected);
    end
    cyc();
    checks++;
    if (selected !== 3'd0 || req_out !== 1'b1) begin
      errors++;
      $display("FAIL single_regrant: selected=%0d req_out=%b expected 0/1", selected, req_out);
    end
    reqs_in = '0;
    cyc();
  endtask

  task automatic test_fairness();
    int exp_order[6] = '{0, 1, 2, 3, 4, 0};
    do_reset();
    reqs_in = 5'b11111;
    for (int i = 0; i < 6; i++) begin
      cyc();
      checks++;
      if (selected !== SB'(exp_order[i]) || req_out !== 1'b1) begin
        errors++;
        $display("FAIL fair_grant[%0d]: selected=%0d req_out=%b expected %0d/1",
                 i, selected, req_out, exp_order[i]);
      end
      ack_out = 1'b1;
      #1;
      checks++;
      if (acks_in !== CH'(1 << exp_order[i])) begin
        errors++;
        $display("FAIL fair_ack[%0d]: acks_in=%b expected %b", i, acks_in, CH'(1 << exp_order[i]));
      end
      cyc();
      reqs_in[exp_order[i]] = 1'b0;
      ack_out = 1'b0;
      cyc();
      reqs_in = 5'b11111;
      #1;
      checks++;
      if (req_out !== 1'b0 || acks_in !== '0) begin
        errors++;
        $display("FAIL fair_idle[%0d]: req_out=%b acks_in=%b expected 0/00000", i, req_out, acks_in);
      end
    end
    reqs_in = '0;
    cyc();
    cyc();
  endtask

  task automatic test_no_preempt();
    do_reset();
    reqs_in = 5'b01000;
    cyc();
    reqs_in = 5'b01010;
    ack_out = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (selected !== 3'd3 || acks_in !== 5'b01000) begin
        errors++;
        $display("FAIL nopre_hold[%0d]: selected=%0d acks_in=%b expected 3/01000", i, selected, acks_in);
      end
    end
    reqs_in = 5'b00010;
    ack_out = 1'b0;
    #1;
    checks++;
    if (req_out !== 1'b0 || acks_in !== '0) begin
      errors++;
      $display("FAIL nopre_release: req_out=%b acks_in=%b expected 0/00000", req_out, acks_in);
    end
    cyc();
    cyc();
    checks++;
    if (selected !== 3'd1 || req_out !== 1'b1) begin
      errors++;
      $display("FAIL nopre_next: selected=%0d req_out=%b expected 1/1", selected, req_out);
    end
    reqs_in = '0;
    cyc();
  endtask

  task automatic test_wrap();
    do_reset();
    reqs_in = 5'b10000;
    cyc();
    checks++;
    if (selected !== 3'd4) begin
      errors++; $display("FAIL wrap_ch4: selected=%0d expected 4", selected);
    end
    reqs_in = '0;
    cyc();
    cyc();
    reqs_in = 5'b10001;
    cyc();
    checks++;
    if (selected !== 3'd0 || req_out !== 1'b1) begin
      errors++;
      $display("FAIL wrap_next: selected=%0d req_out=%b expected 0/1", selected, req_out);
    end
    reqs_in = '0;
    cyc();
  endtask

  task automatic test_spurious_ack();
    do_reset();
    ack_out = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (acks_in !== '0 || req_out !== 1'b0) begin
        errors++;
        $display("FAIL spur_ack[%0d]: acks_in=%b req_out=%b expected 00000/0", i, acks_in, req_out);
      end
    end
    ack_out = 1'b0;
    reqs_in = 5'b00010;
    cyc();
    checks++;
    if (selected !== 3'd1 || req_out !== 1'b1) begin
      errors++;
      $display("FAIL spur_still_idle: selected=%0d req_out=%b expected 1/1", selected, req_out);
    end
    reqs_in = '0;
    cyc();
  endtask

  task automatic test_reset_mid();
    do_reset();
    reqs_in = 5'b00100;
    cyc();
    ack_out = 1'b1;
    #1;
    checks++;
    if (acks_in !== 5'b00100 || req_out !== 1'b1) begin
      errors++;
      $display("FAIL rmid_busy: acks_in=%b req_out=%b expected 00100/1", acks_in, req_out);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (req_out !== 1'b0 || acks_in !== '0 || selected !== '0) begin
      errors++;
      $display("FAIL rmid_drop: req_out=%b acks_in=%b selected=%0d expected 0/00000/0",
               req_out, acks_in, selected);
    end
    ack_out = 1'b0;
    reqs_in = 5'b10001;
    @(posedge clk);
    #3 reset = 1'b1;
    cyc();
    checks++;
    if (selected !== 3'd0 || req_out !== 1'b1) begin
      errors++;
      $display("FAIL rmid_prio: selected=%0d req_out=%b expected 0/1", selected, req_out);
    end
    reqs_in = '0;
    cyc();
  endtask

  task automatic test_random();
    logic [CH-1:0] exp_acks;
    logic          exp_req;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      cyc();
      reqs_in = CH'($urandom_range(0, 31) & $urandom_range(0, 31));
      ack_out = ($urandom_range(0, 2) == 0);
      #3;
      exp_acks = '0;
      exp_req  = 1'b0;
      if (m_busy) begin
        exp_req          = reqs_in[m_sel];
        exp_acks[m_sel]  = ack_out;
      end
      checks++;
      if (req_out !== exp_req || acks_in !== exp_acks || (m_busy && selected !== SB'(m_sel))) begin
        errors++;
        $display("FAIL rand[%0d]: req_out=%b acks_in=%b selected=%0d expected %b/%b/%0d",
                 n, req_out, acks_in, selected, exp_req, exp_acks, m_sel);
      end
    end
    reqs_in = '0;
    ack_out = 1'b0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_no_preempt();
    test_wrap();
    test_spurious_ack();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
